// File: rtl/test_status_responder.sv
// test_status_responder: memory-mapped pass/fail/timeout verdict latch and signature FIFO on the core data bus
// Ports: clk/reset (async active-low); bus_req/we/addr/wdata in, bus_ack/rdata out (one-cycle registered response);
//        test_done/test_pass/fail_code verdict; sig_valid/sig_data/sig_pop/sig_overflow signature FIFO; cycle_count.
module test_status_responder #(
    parameter int                     BIT_COUNT      = 32,
    parameter logic [BIT_COUNT-1:0]   TOHOST_ADDR    = 32'h0000_1000,
    parameter logic [BIT_COUNT-1:0]   CYCLE_ADDR     = 32'h0000_1004,
    parameter logic [BIT_COUNT-1:0]   SIG_ADDR       = 32'h0000_1008,
    parameter int                     SIG_DEPTH      = 16,
    parameter int                     TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bus_req,
    input  logic                 bus_we,
    input  logic [BIT_COUNT-1:0] bus_addr,
    input  logic [BIT_COUNT-1:0] bus_wdata,
    output logic                 bus_ack,
    output logic [BIT_COUNT-1:0] bus_rdata,
    output logic                 test_done,
    output logic                 test_pass,
    output logic [BIT_COUNT-2:0] fail_code,
    output logic                 sig_valid,
    output logic [BIT_COUNT-1:0] sig_data,
    input  logic                 sig_pop,
    output logic                 sig_overflow,
    output logic [BIT_COUNT-1:0] cycle_count
);
    localparam int                   AW      = $clog2(SIG_DEPTH);
    localparam logic [BIT_COUNT-1:0] AMASK   = ~BIT_COUNT'(3);
    localparam logic [BIT_COUNT-1:0] TO_LAST = BIT_COUNT'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RUNNING, PASSED, FAILED, TIMEOUT} state_t;

    state_t               state_q, state_d;
    logic [BIT_COUNT-1:0] tohost_q, tohost_d, cycle_q, cycle_d, rdata_q, rdata_d;
    logic                 ack_q, ack_d, ovf_q, ovf_d;
    logic [AW:0]          wp_q, wp_d, rp_q, rp_d;
    logic [BIT_COUNT-1:0] fifo_mem_q [SIG_DEPTH];
    logic                 hit_tohost, hit_cycle, hit_sig, wr_tohost, push_req, push, pop, empty, full, running;

    // Byte-lane bits are masked off so any byte address within a word decodes to it.
    always_comb begin
        hit_tohost = (bus_addr & AMASK) == (TOHOST_ADDR & AMASK);
        hit_cycle  = (bus_addr & AMASK) == (CYCLE_ADDR & AMASK);
        hit_sig    = (bus_addr & AMASK) == (SIG_ADDR & AMASK);
        wr_tohost  = bus_req && bus_we && hit_tohost;
        push_req   = bus_req && bus_we && hit_sig;
        running    = state_q == RUNNING;
        empty      = wp_q == rp_q;
        full       = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        pop        = sig_pop && !empty;
        // A pop in the same cycle frees the slot, so a push while full still lands.
        push       = push_req && (!full || pop);
        state_d    = !running ? state_q :
                     wr_tohost ? (bus_wdata == BIT_COUNT'(1) ? PASSED : bus_wdata[0] ? FAILED : RUNNING) :
                     cycle_q == TO_LAST ? TIMEOUT : RUNNING;
        tohost_d   = (running && wr_tohost) ? bus_wdata : tohost_q;
        cycle_d    = running ? cycle_q + 1'b1 : cycle_q;
        ack_d      = bus_req;
        rdata_d    = (bus_req && !bus_we) ? (hit_tohost ? tohost_q : hit_cycle ? cycle_q : '0) : '0;
        wp_d       = push ? wp_q + 1'b1 : wp_q;
        rp_d       = pop ? rp_q + 1'b1 : rp_q;
        ovf_d      = ovf_q || (push_req && full && !pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUNNING;
            tohost_q <= '0;
            cycle_q  <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tohost_q <= tohost_d;
            cycle_q  <= cycle_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wp_q[AW-1:0]] <= bus_wdata;
    end

    always_comb begin
        bus_ack      = ack_q;
        bus_rdata    = rdata_q;
        test_done    = !running;
        test_pass    = state_q == PASSED;
        fail_code    = state_q == FAILED ? tohost_q[BIT_COUNT-1:1] : state_q == TIMEOUT ? '1 : '0;
        sig_valid    = !empty;
        // Storage is not reset, so the head is masked to keep outputs at 0 while empty.
        sig_data     = empty ? '0 : fifo_mem_q[rp_q[AW-1:0]];
        sig_overflow = ovf_q;
        cycle_count  = cycle_q;
    end
endmodule

// File: tb/tb_test_status_responder.sv
// tb_test_status_responder: directed scoreboard bench for test_status_responder
module tb_test_status_responder;
    localparam logic [31:0] TOHOST = 32'h1000, CYC = 32'h1004, SIG = 32'h1008, UNMAP = 32'h2000;

    logic        clk, reset, bus_req, bus_we, bus_ack, test_done, test_pass, sig_valid, sig_pop, sig_overflow;
    logic [31:0] bus_addr, bus_wdata, bus_rdata, sig_data, cycle_count;
    logic [30:0] fail_code;
    logic [31:0] rq [$];
    logic [31:0] sq [$];
    int          checks = 0, errors = 0, n;

    test_status_responder #(.TIMEOUT_CYCLES(20), .SIG_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .test_done(test_done),
        .test_pass(test_pass), .fail_code(fail_code), .sig_valid(sig_valid), .sig_data(sig_data),
        .sig_pop(sig_pop), .sig_overflow(sig_overflow), .cycle_count(cycle_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reads push their expected data; the value is popped and compared in the ack cycle.
    task automatic acc(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
        bus_req = 1; bus_we = we; bus_addr = a; bus_wdata = d;
        if (!we) rq.push_back(e);
        tick();
        bus_req = 0;
        chk("ack", {31'd0, bus_ack}, 32'd1);
        if (!we) chk("rdata", bus_rdata, rq.pop_front());
    endtask

    task automatic push_sig(input logic [31:0] d);
        if (sq.size() < 4 || sig_pop) sq.push_back(d);
        acc(1, SIG, d, 0);
    endtask

    task automatic pop_sig();
        chk("pop_valid", {31'd0, sig_valid}, 32'd1);
        chk("pop_data", sig_data, sq.pop_front());
        sig_pop = 1;
        tick();
        sig_pop = 0;
    endtask

    task automatic rst_pulse();
        reset = 0;
        #2;
        reset = 1;
        sq.delete();
    endtask

    initial begin
        reset = 0; bus_req = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0; sig_pop = 0;
        repeat (2) tick();
        chk("rst_done", {31'd0, test_done}, 0);
        chk("rst_pass", {31'd0, test_pass}, 0);
        chk("rst_fail", {1'b0, fail_code}, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_valid", {31'd0, sig_valid}, 0);
        reset = 1;
        // pass after 5 idle cycles
        repeat (5) tick();
        chk("idle_cycle", cycle_count, 5);
        acc(1, TOHOST, 1, 0);
        chk("pass_done", {31'd0, test_done}, 1);
        chk("pass_pass", {31'd0, test_pass}, 1);
        chk("pass_fail", {1'b0, fail_code}, 0);
        chk("pass_cycle", cycle_count, 6);
        tick();
        chk("ack_drop", {31'd0, bus_ack}, 0);
        acc(0, CYC, 0, 6);
        acc(0, TOHOST, 0, 1);
        push_sig(32'hC1);
        push_sig(32'hC2);
        chk("buf_head", sig_data, 32'hC1);
        // async reset between edges
        #2 reset = 0;
        #1;
        chk("arst_done", {31'd0, test_done}, 0);
        chk("arst_pass", {31'd0, test_pass}, 0);
        chk("arst_valid", {31'd0, sig_valid}, 0);
        chk("arst_data", sig_data, 0);
        chk("arst_cycle", cycle_count, 0);
        chk("arst_ack", {31'd0, bus_ack}, 0);
        reset = 1;
        sq.delete();
        acc(0, CYC, 0, 0);
        acc(0, TOHOST, 0, 0);
        // fail code and frozen verdict
        rst_pulse();
        acc(1, TOHOST, 2, 0);
        chk("even_done", {31'd0, test_done}, 0);
        acc(0, TOHOST, 0, 2);
        acc(1, TOHOST, 7, 0);
        chk("fail_done", {31'd0, test_done}, 1);
        chk("fail_pass", {31'd0, test_pass}, 0);
        chk("fail_code", {1'b0, fail_code}, 3);
        acc(1, TOHOST, 1, 0);
        chk("frozen_pass", {31'd0, test_pass}, 0);
        chk("frozen_code", {1'b0, fail_code}, 3);
        acc(0, TOHOST, 0, 7);
        acc(1, UNMAP, 32'h55, 0);
        acc(0, UNMAP, 0, 0);
        acc(0, SIG, 0, 0);
        // timeout
        rst_pulse();
        n = 0;
        while (n < 30 && !test_done) begin
            tick();
            n++;
        end
        chk("to_edges", n, 20);
        chk("to_pass", {31'd0, test_pass}, 0);
        chk("to_code", {1'b0, fail_code}, 32'h7FFF_FFFF);
        chk("to_cycle", cycle_count, 20);
        rst_pulse();
        repeat (19) tick();
        chk("pre_to_done", {31'd0, test_done}, 0);
        acc(1, TOHOST, 1, 0);
        chk("race_pass", {31'd0, test_pass}, 1);
        chk("race_code", {1'b0, fail_code}, 0);
        // fifo fill and overflow
        rst_pulse();
        push_sig(32'hA0);
        chk("first_valid", {31'd0, sig_valid}, 1);
        chk("first_data", sig_data, 32'hA0);
        for (int i = 1; i < 5; i++) push_sig(32'hA0 + i);
        chk("ovf_set", {31'd0, sig_overflow}, 1);
        repeat (4) pop_sig();
        chk("drained", {31'd0, sig_valid}, 0);
        sig_pop = 1;
        tick();
        sig_pop = 0;
        chk("extra_pop", {31'd0, sig_valid}, 0);
        chk("ovf_sticky", {31'd0, sig_overflow}, 1);
        // simultaneous push and pop while full
        rst_pulse();
        for (int i = 0; i < 4; i++) push_sig(32'hA0 + i);
        chk("full_ovf", {31'd0, sig_overflow}, 0);
        sig_pop = 1;
        void'(sq.pop_front());
        push_sig(32'hB0);
        sig_pop = 0;
        chk("pp_ovf", {31'd0, sig_overflow}, 0);
        repeat (4) pop_sig();
        chk("pp_empty", {31'd0, sig_valid}, 0);
        sig_pop = 1;
        push_sig(32'hC0);
        sig_pop = 0;
        chk("ep_valid", {31'd0, sig_valid}, 1);
        chk("ep_data", sig_data, 32'hC0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
